// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one combinational fp32 add/sub core; result ready CALC_CYCLES+1 cycles after accept.
// Single transaction in flight; req_ready held low until the response handshakes on rsp_ready.

module floating_unit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        a_s,
    output logic [31:0] y
);
    logic        sa, sb, a_nan, b_nan, a_inf, b_inf, swap, eff_sub, sign_big, rnd;
    logic [7:0]  ea, eb, ea_eff, eb_eff, e_big, e_small, d;
    logic [23:0] ma, mb, m_big, m_small, m_f;
    logic [49:0] sh50;
    logic [26:0] big27, small27, mn;
    logic [27:0] s28;
    logic [9:0]  e_n, e_f;
    logic [4:0]  lz, shl;
    logic [24:0] m_r;

    always_comb begin
        sa      = a[31];
        sb      = b[31] ^ a_s;
        ea      = a[30:23];
        eb      = b[30:23];
        ma      = {ea != 8'd0, a[22:0]};
        mb      = {eb != 8'd0, b[22:0]};
        ea_eff  = (ea == 8'd0) ? 8'd1 : ea;
        eb_eff  = (eb == 8'd0) ? 8'd1 : eb;
        a_nan   = (ea == 8'hFF) && (a[22:0] != 23'd0);
        b_nan   = (eb == 8'hFF) && (b[22:0] != 23'd0);
        a_inf   = (ea == 8'hFF) && (a[22:0] == 23'd0);
        b_inf   = (eb == 8'hFF) && (b[22:0] == 23'd0);
        swap    = {eb, b[22:0]} > {ea, a[22:0]};
        e_big   = swap ? eb_eff : ea_eff;
        e_small = swap ? ea_eff : eb_eff;
        m_big   = swap ? mb : ma;
        m_small = swap ? ma : mb;
        sign_big = swap ? sb : sa;
        eff_sub = sa ^ sb;
        d       = e_big - e_small;

        // Align the smaller operand, folding everything shifted past the round bit into sticky.
        sh50    = {m_small, 26'd0} >> ((d > 8'd31) ? 8'd31 : d);
        small27 = {sh50[49:24], |sh50[23:0]};
        big27   = {m_big, 3'b000};
        s28     = eff_sub ? ({1'b0, big27} - {1'b0, small27})
                          : ({1'b0, big27} + {1'b0, small27});

        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (s28[i]) lz = 5'(26 - i);
        end

        shl = 5'd0;
        if (s28[27]) begin
            mn  = {s28[27:2], s28[1] | s28[0]};
            e_n = {2'b00, e_big} + 10'd1;
        end else begin
            // Never normalise below the minimum exponent; the remainder stays subnormal.
            if ({5'd0, lz} > ({2'b00, e_big} - 10'd1)) shl = 5'(e_big - 8'd1);
            else                                        shl = lz;
            mn  = s28[26:0] << shl;
            e_n = {2'b00, e_big} - {5'd0, shl};
        end

        rnd = mn[2] & (mn[1] | mn[0] | mn[3]);
        m_r = {1'b0, mn[26:3]} + {24'd0, rnd};
        m_f = m_r[24] ? m_r[24:1] : m_r[23:0];
        e_f = m_r[24] ? (e_n + 10'd1) : e_n;

        if (s28 == 28'd0)        y = {sa & sb, 31'd0};
        else if (e_f >= 10'd255) y = {sign_big, 8'hFF, 23'd0};
        else                     y = {sign_big, m_f[23] ? e_f[7:0] : 8'd0, m_f[22:0]};

        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) y = 32'h7FC00000;
        else if (a_inf)                                    y = {sa, 8'hFF, 23'd0};
        else if (b_inf)                                    y = {sb, 8'hFF, 23'd0};
    end
endmodule

module fp_add_scheduler #(
    parameter  int N_REQ       = 4,
    parameter  int CALC_CYCLES = 2,
    localparam int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    input  logic [N_REQ-1:0]      req_op,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [31:0]           rsp_result,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy,
    output logic [15:0]           op_count
);
    localparam int CNT_W = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
    localparam logic [N_REQ-1:0] ONE_HOT = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        op_a_q, op_a_d, op_b_q, op_b_d;
    logic               op_s_q, op_s_d;
    logic [31:0]        rsp_result_q, rsp_result_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [15:0]        op_count_q, op_count_d;
    logic               busy_q, busy_d;
    logic [ID_W-1:0]    winner;
    logic               win_vld;
    logic [31:0]        add_y;
    int                 idx;

    floating_unit u_fadd (
        .a   (op_a_q),
        .b   (op_b_q),
        .a_s (op_s_q),
        .y   (add_y)
    );

    // Walk from lowest to highest priority so the closest valid requester after last_grant wins.
    always_comb begin
        winner  = last_grant_q;
        win_vld = 1'b0;
        idx     = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last_grant_q) + k) % N_REQ;
            if (req_valid[idx]) begin
                win_vld = 1'b1;
                winner  = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(N_REQ - 1);
            rsp_id_q     <= '0;
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_s_q       <= 1'b0;
            rsp_result_q <= '0;
            rsp_valid_q  <= '0;
            op_count_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_s_q       <= op_s_d;
            rsp_result_q <= rsp_result_d;
            rsp_valid_q  <= rsp_valid_d;
            op_count_q   <= op_count_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_vld) state_d = CALC;
            CALC:    if (cnt_q == '0) state_d = RESP;
            RESP:    if (rsp_ready[rsp_id_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_s_d       = op_s_q;
        rsp_result_d = rsp_result_q;
        rsp_valid_d  = rsp_valid_q;
        op_count_d   = op_count_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    req_ready    = ONE_HOT << winner;
                    op_a_d       = req_a[32*int'(winner) +: 32];
                    op_b_d       = req_b[32*int'(winner) +: 32];
                    op_s_d       = req_op[winner];
                    rsp_id_d     = winner;
                    last_grant_d = winner;
                    cnt_d        = CNT_W'(CALC_CYCLES - 1);
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    rsp_result_d = add_y;
                    rsp_valid_d  = ONE_HOT << rsp_id_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready[rsp_id_q]) begin
                    rsp_valid_d = '0;
                    op_count_d  = op_count_q + 16'd1;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = busy_q;
    assign op_count   = op_count_q;
endmodule

// File: tb/tb_fp_add_scheduler.sv
// Directed bench for fp_add_scheduler: stimulus pushes expected responses at accept, a negedge monitor checks them.

module tb_fp_add_scheduler;
    localparam int N    = 4;
    localparam int CALC = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid, req_ready, req_op, rsp_valid, rsp_ready;
    logic [32*N-1:0]   req_a, req_b;
    logic [31:0]       rsp_result;
    logic [1:0]        rsp_id;
    logic              busy;
    logic [15:0]       op_count;

    fp_add_scheduler #(.N_REQ(N), .CALC_CYCLES(CALC)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_id(rsp_id),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [31:0] res; int cyc; } exp_t;
    exp_t        sb[$];
    exp_t        e;
    logic [31:0] exp_tab [N];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_miss = 0;
    int          exp_opcount = 0;
    bit          in_resp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: records accepts and checks every response presentation.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            in_resp     = 0;
            exp_opcount = 0;
        end else begin
            check("op_count", {16'd0, op_count}, exp_opcount);
            check("req_ready_onehot", ($countones(req_ready) <= 1), 1);
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i]) sb.push_back('{i, exp_tab[i], cyc});
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", {28'd0, rsp_valid}, 32'd0);
                end else begin
                    e = sb[0];
                    if (!in_resp) begin
                        check("rsp_latency", cyc - e.cyc, CALC + 1);
                        check("rsp_valid", {28'd0, rsp_valid}, 32'd1 << e.id);
                        check("rsp_id", {30'd0, rsp_id}, e.id);
                        check("rsp_result", rsp_result, e.res);
                        in_resp = 1;
                    end
                    if (rsp_ready[e.id]) begin
                        void'(sb.pop_front());
                        in_resp = 0;
                        exp_opcount++;
                    end
                end
            end
        end
    end

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic op, input logic [31:0] res);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_op[id]         = op;
        exp_tab[id]        = res;
        req_valid[id]      = 1'b1;
    endtask

    // Waits for the next accept and checks it went to the expected requester.
    task automatic accept_expect(input int id, output int c);
        bit got = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                got = 1;
                break;
            end
        end
        if (!got) check("accept_timeout", {28'd0, req_ready}, 32'd1 << id);
        else      check("grant", {28'd0, req_ready}, 32'd1 << id);
        c = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) check("idle_timeout", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic op, input logic [31:0] res);
        int c;
        set_req(id, a, b, op, res);
        accept_expect(id, c);
        req_valid[id] = 1'b0;
        wait_idle();
    endtask

    initial begin
        int c, prev;
        int rr_order [5] = '{0, 1, 2, 3, 0};
        logic [31:0] held;

        rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = '1;
        for (int i = 0; i < N; i++) exp_tab[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_op_count", {16'd0, op_count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single add, then subtract routed only to requester 1.
        run_one(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
        check("op_count_after_add", {16'd0, op_count}, 32'd1);
        run_one(1, 32'h40A00000, 32'h40400000, 1'b1, 32'h40000000);

        // Sign, cancellation, infinity and rounding cases; ends on requester 3.
        run_one(2, 32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000);
        run_one(3, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000);
        run_one(2, 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000);
        run_one(2, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000);
        run_one(3, 32'h3F800000, 32'h34400000, 1'b0, 32'h3F800002);

        // Round-robin with all requesters continuously valid.
        set_req(0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
        set_req(1, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000);
        set_req(2, 32'h40400000, 32'h40800000, 1'b0, 32'h40E00000);
        set_req(3, 32'h3F000000, 32'h3E800000, 1'b0, 32'h3F400000);
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            accept_expect(rr_order[k], c);
            if (k > 0) check("rr_spacing", c - prev, CALC + 2);
            prev = c;
        end
        req_valid = '0;
        wait_idle();

        // Priority rotation: after req 2, req 0 beats req 2.
        run_one(2, 32'h40400000, 32'h40800000, 1'b0, 32'h40E00000);
        set_req(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
        set_req(2, 32'h40A00000, 32'h40400000, 1'b1, 32'h40000000);
        accept_expect(0, c);
        req_valid[0] = 1'b0;
        accept_expect(2, c);
        req_valid[2] = 1'b0;
        wait_idle();

        // Backpressure on req 1 with its operand changed in flight; req 3 waits.
        rsp_ready = 4'b1101;
        set_req(1, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
        accept_expect(1, c);
        req_valid[1] = 1'b0;
        req_a[63:32] = 32'h41200000;
        set_req(3, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (rsp_valid != '0) break;
        end
        held = exp_opcount;
        for (int t = 0; t < 5; t++) begin
            check("bp_rsp_valid", {28'd0, rsp_valid}, 32'h2);
            check("bp_result", rsp_result, 32'h40400000);
            check("bp_req_ready", {28'd0, req_ready}, 32'd0);
            check("bp_op_count", {16'd0, op_count}, held);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = '1;
        accept_expect(3, c);
        req_valid[3] = 1'b0;
        wait_idle();

        // Reset in the first CALC cycle aborts req 1; req 0 then wins over req 3.
        set_req(1, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
        accept_expect(1, c);
        req_valid[1] = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        check("abort_result", rsp_result, 32'd0);
        check("abort_rsp_id", {30'd0, rsp_id}, 32'd0);
        check("abort_op_count", {16'd0, op_count}, 32'd0);
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        set_req(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
        set_req(3, 32'h3F000000, 32'h3E800000, 1'b0, 32'h3F400000);
        accept_expect(0, c);
        req_valid[0] = 1'b0;
        accept_expect(3, c);
        req_valid[3] = 1'b0;
        wait_idle();
        check("final_op_count", {16'd0, op_count}, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        n_miss++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "watchdog");
    end
endmodule
